// File: rtl/aes_io_pkg.sv
// Shared types for the AES register read-out path: serializer states and the 128-bit block type.
package aes_io_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [127:0] aes_block_t;

endpackage

// File: rtl/aes_word_select.sv
// Combinational word picker: returns word[index] of a 128-bit block in emission order.
module aes_word_select
  import aes_io_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter bit MSW_FIRST = 1'b1
) (
  input  aes_block_t        blk,
  input  logic [1:0]        index,
  output logic [WORD_W-1:0] word
);

  logic [1:0] sel;

  // Emission index 0 maps to the top word when MSW_FIRST, else to the bottom word.
  always_comb begin
    sel = MSW_FIRST ? (2'd3 - index) : index;
    case (sel)
      2'd0:    word = blk[WORD_W-1:0];
      2'd1:    word = blk[2*WORD_W-1:WORD_W];
      2'd2:    word = blk[3*WORD_W-1:2*WORD_W];
      default: word = blk[4*WORD_W-1:3*WORD_W];
    endcase
  end

endmodule

// File: rtl/aes_block_serializer.sv
// Accepts 128-bit AES blocks and drains them as four 32-bit words, with a one-deep
// pending buffer so the next block can be taken while the current one drains.
module aes_block_serializer
  import aes_io_pkg::*;
#(
  parameter int BLOCK_W   = 128,
  parameter int WORD_W    = 32,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [BLOCK_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WORD_W-1:0] Out_Data,
  output logic [1:0]        Out_Index,
  output logic              Out_Last,
  output logic              Busy
);

  ser_state_t state_q, state_d;
  logic [1:0] index_q, index_d;
  aes_block_t active_q, active_d;
  aes_block_t pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;

  logic in_fire, out_fire, last_word;

  assign In_Ready  = !pend_valid_q;
  assign Out_Valid = (state_q == SEND);
  assign Out_Index = index_q;
  assign last_word = (index_q == 2'(WORDS_PER_BLOCK - 1));
  assign Out_Last  = Out_Valid && last_word;
  assign Busy      = (state_q == SEND) || pend_valid_q;
  assign in_fire   = In_Valid && In_Ready;
  assign out_fire  = Out_Valid && Out_Ready;

  aes_word_select #(
    .WORD_W    (WORD_W),
    .MSW_FIRST (MSW_FIRST)
  ) u_word_select (
    .blk   (active_q),
    .index (index_q),
    .word  (Out_Data)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          active_d = aes_block_t'(In_Data);
          index_d  = 2'd0;
          state_d  = SEND;
        end
      end
      default: begin
        if (out_fire && !last_word) begin
          index_d = index_q + 2'd1;
        end else if (out_fire) begin
          // Last word leaving: refill from pending, else bypass a same-edge block, else idle.
          index_d = 2'd0;
          if (pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = 1'b0;
          end else if (in_fire) begin
            active_d = aes_block_t'(In_Data);
          end else begin
            state_d = IDLE;
          end
        end
        if (in_fire && !(out_fire && last_word)) begin
          pend_d       = aes_block_t'(In_Data);
          pend_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      index_q      <= 2'd0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule
